// File: rtl/afifo_wr_arbiter_if.sv
// rtl/afifo_wr_arbiter_if.sv - requester and afifo write-port bundle for afifo_wr_arbiter
interface afifo_wr_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    grant;
    logic               full;
    logic               write_en;
    logic [DW-1:0]      w_data;
    logic               busy;
    logic [CW-1:0]      burst_cnt;

    // arbiter side: drives the afifo write port and the requester acks
    modport master (
        input  req, req_data, full,
        output ack, grant, write_en, w_data, busy, burst_cnt
    );

    // requester / afifo side
    modport slave (
        output req, req_data, full,
        input  ack, grant, write_en, w_data, busy, burst_cnt
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - round-robin burst arbiter for the afifo write port
module afifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               w_clk,
    input  logic               clr_n,
    afifo_wr_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] PTR_INIT = IW'(NREQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   winner;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            any_req;
    logic            req_own;
    logic            accept;
    logic [DW-1:0]   data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data[g*DW +: DW];
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.burst_cnt = cnt_q;

    // first requester after the last owner, wrapping modulo NREQ
    always_comb begin
        int idx;
        logic [IW-1:0] pos;
        idx     = 0;
        pos     = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            pos = IW'(idx);
            if (!any_req && bus.req[pos]) begin
                any_req = 1'b1;
                winner  = pos;
            end
        end
    end

    // sequencing registers; reset abandons any burst immediately
    always_ff @(posedge w_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= PTR_INIT;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // next state plus same-cycle write strobe, ack and data mux
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        bus.ack      = '0;
        bus.write_en = 1'b0;
        bus.w_data   = data_arr[owner_q];
        req_own      = bus.req[owner_q];
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d          = BURST;
                    owner_d          = winner;
                    cnt_d            = '0;
                    grant_d          = '0;
                    grant_d[winner]  = 1'b1;
                end
            end
            BURST: begin
                accept           = req_own & ~bus.full;
                bus.write_en     = accept;
                bus.ack[owner_q] = accept;
                if (!req_own || (accept && cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// tb/tb_afifo_wr_arbiter.sv - directed self-checking bench for afifo_wr_arbiter
module tb_afifo_wr_arbiter;
    logic       w_clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [3:0] req_v = 4'b0000;
    logic [3:0] req1_v = 4'b0000;
    logic       full_v = 1'b0;
    logic [7:0] dval [4];
    logic [3:0] ack_s = 4'b0000;
    int         checks = 0;
    int         failures = 0;

    int g4 [10] = '{0, 2, 2, 0, 8, 8, 8, 8, 0, 1};
    int d4 [10] = '{0, 'h10, 0, 0, 'h30, 'h31, 'h32, 'h33, 0, 'h00};
    int g6 [9]  = '{0, 1, 0, 2, 0, 1, 0, 2, 0};

    always #5 w_clk = ~w_clk;

    afifo_wr_arbiter_if #(.NREQ(4), .DW(8), .MAX_BURST(4)) bus ();
    afifo_wr_arbiter_if #(.NREQ(4), .DW(8), .MAX_BURST(1)) bus1 ();

    assign bus.req       = req_v;
    assign bus.req_data  = {dval[3], dval[2], dval[1], dval[0]};
    assign bus.full      = full_v;
    assign bus1.req      = req1_v;
    assign bus1.req_data = {8'h00, 8'h00, 8'hB1, 8'hA0};
    assign bus1.full     = 1'b0;

    afifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .w_clk (w_clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    afifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(1)) dut1 (
        .w_clk (w_clk),
        .clr_n (clr_n),
        .bus   (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge w_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack_s[i]) dval[i] = dval[i] + 8'd1;
        end
        ack_s = 4'b0000;
    endtask

    task automatic sample();
        @(negedge w_clk);
        ack_s = bus.ack;
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [3:0] r1);
        clr_n  = 1'b0;
        ack_s  = 4'b0000;
        req_v  = r;
        req1_v = r1;
        full_v = 1'b0;
        dval   = '{8'h00, 8'h10, 8'h20, 8'h30};
        @(negedge w_clk);
        check_eq("rst_grant", 32'(bus.grant), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_cnt", 32'(bus.burst_cnt), 0);
        check_eq("rst_we", 32'(bus.write_en), 0);
        check_eq("rst_ack", 32'(bus.ack), 0);
        @(posedge w_clk);
        #1;
        clr_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int phase, grp, own, wr_n, we;

        // single requester, continuous: 4 writes then one bubble
        do_reset(4'b0001, 4'b0000);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) next_cycle();
            sample();
            phase = (c - 1) % 5;
            grp   = (c - 1) / 5;
            check_eq($sformatf("t1_we_c%0d", c), 32'(bus.write_en), (phase != 0) ? 1 : 0);
            check_eq($sformatf("t1_grant_c%0d", c), 32'(bus.grant), (phase != 0) ? 1 : 0);
            check_eq($sformatf("t1_cnt_c%0d", c), 32'(bus.burst_cnt), (phase != 0) ? phase - 1 : 0);
            if (phase != 0)
                check_eq($sformatf("t1_data_c%0d", c), 32'(bus.w_data), grp * 4 + phase - 1);
        end

        // all four requesting: round-robin bursts of 4
        do_reset(4'b1111, 4'b0000);
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) next_cycle();
            sample();
            phase = (c - 1) % 5;
            grp   = (c - 1) / 5;
            own   = grp % 4;
            if (phase == 0) begin
                check_eq($sformatf("t2_we_c%0d", c), 32'(bus.write_en), 0);
                check_eq($sformatf("t2_grant_c%0d", c), 32'(bus.grant), 0);
                check_eq($sformatf("t2_busy_c%0d", c), 32'(bus.busy), 0);
            end else begin
                check_eq($sformatf("t2_we_c%0d", c), 32'(bus.write_en), 1);
                check_eq($sformatf("t2_grant_c%0d", c), 32'(bus.grant), 1 << own);
                check_eq($sformatf("t2_ack_c%0d", c), 32'(bus.ack), 1 << own);
                check_eq($sformatf("t2_cnt_c%0d", c), 32'(bus.burst_cnt), phase - 1);
                check_eq($sformatf("t2_data_c%0d", c), 32'(bus.w_data),
                         own * 16 + (grp / 4) * 4 + phase - 1);
            end
        end

        // owner 2 stalled by full after its second word
        do_reset(4'b0100, 4'b0000);
        wr_n = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) next_cycle();
            full_v = (c >= 4 && c <= 8);
            sample();
            we = (c == 1 || c == 11 || (c >= 4 && c <= 8)) ? 0 : 1;
            check_eq($sformatf("t3_we_c%0d", c), 32'(bus.write_en), we);
            check_eq($sformatf("t3_ack_c%0d", c), 32'(bus.ack), we ? 4 : 0);
            check_eq($sformatf("t3_grant_c%0d", c), 32'(bus.grant), (c == 1 || c == 11) ? 0 : 4);
            check_eq($sformatf("t3_cnt_c%0d", c), 32'(bus.burst_cnt),
                     (c <= 2) ? 0 : (c == 3) ? 1 : (c <= 9) ? 2 : (c == 10) ? 3 : 0);
            if (we) begin
                check_eq($sformatf("t3_data_c%0d", c), 32'(bus.w_data), 'h20 + wr_n);
                wr_n++;
            end
        end
        full_v = 1'b0;

        // owner 1 drops after one word; search resumes from 2
        do_reset(4'b0010, 4'b0000);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) next_cycle();
            if (c == 2) req_v = 4'b1011;
            if (c == 3) req_v = 4'b1001;
            sample();
            we = (c == 2 || (c >= 5 && c <= 8) || c == 10) ? 1 : 0;
            check_eq($sformatf("t4_grant_c%0d", c), 32'(bus.grant), g4[c-1]);
            check_eq($sformatf("t4_we_c%0d", c), 32'(bus.write_en), we);
            if (we) check_eq($sformatf("t4_data_c%0d", c), 32'(bus.w_data), d4[c-1]);
            if (c == 3) check_eq("t4_cnt_drop", 32'(bus.burst_cnt), 1);
        end

        // asynchronous reset mid-burst of owner 3
        do_reset(4'b1000, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) next_cycle();
            sample();
        end
        check_eq("t5_pre_cnt", 32'(bus.burst_cnt), 2);
        check_eq("t5_pre_grant", 32'(bus.grant), 8);
        check_eq("t5_pre_data", 32'(bus.w_data), 'h32);
        clr_n = 1'b0;
        req_v = 4'b1001;
        ack_s = 4'b0000;
        #1;
        check_eq("t5_rst_grant", 32'(bus.grant), 0);
        check_eq("t5_rst_busy", 32'(bus.busy), 0);
        check_eq("t5_rst_we", 32'(bus.write_en), 0);
        check_eq("t5_rst_ack", 32'(bus.ack), 0);
        @(posedge w_clk);
        #1;
        clr_n = 1'b1;
        sample();
        check_eq("t5_rel_grant", 32'(bus.grant), 0);
        next_cycle();
        sample();
        check_eq("t5_first_grant", 32'(bus.grant), 1);
        check_eq("t5_first_we", 32'(bus.write_en), 1);
        check_eq("t5_first_data", 32'(bus.w_data), 'h00);
        req_v = 4'b0000;

        // MAX_BURST=1: alternating single-word grants with bubbles
        do_reset(4'b0000, 4'b0011);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) next_cycle();
            sample();
            check_eq($sformatf("t6_grant_c%0d", c), 32'(bus1.grant), g6[c-1]);
            check_eq($sformatf("t6_we_c%0d", c), 32'(bus1.write_en), (g6[c-1] != 0) ? 1 : 0);
            check_eq($sformatf("t6_cnt_c%0d", c), 32'(bus1.burst_cnt), 0);
            if (g6[c-1] != 0)
                check_eq($sformatf("t6_data_c%0d", c), 32'(bus1.w_data), (g6[c-1] == 1) ? 'hA0 : 'hB1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in front of the afifo write side.
- Shares the single write_en/w_data port among NREQ requesters, in bursts of up to MAX_BURST words per grant.
- Runs entirely in the w_clk domain and honours the FIFO full flag on every cycle.
- Sequencing is registered: state, owner, burst counter and round-robin pointer. The write strobe and data mux are same-cycle, so no write is ever in flight when full rises.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width, matches afifo w_data
MAX_BURST, 4, maximum words accepted per grant (1..16)

Ports:
w_clk  input  1  write-domain clock, rising edge
clr_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request; held high while the requester has a word presented
req_data  input  NREQ*DW  flattened data; requester i occupies bits [i*DW +: DW]
ack  output  NREQ  one-hot, combinational; word from the owner accepted this cycle
grant  output  NREQ  one-hot registered owner indication, 0 when idle
full  input  1  afifo full flag
write_en  output  1  afifo write strobe, combinational
w_data  output  DW  afifo write data, combinational
busy  output  1  registered, 1 in BURST
burst_cnt  output  clog2(MAX_BURST+1)  registered count of words accepted in the current grant

Behaviour:
- Reset (clr_n=0, asynchronous):
  - State IDLE; grant=0; busy=0; burst_cnt=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - write_en=0 and ack=0 while in reset.
- Reset asserted mid-burst: the burst is abandoned at once with no further writes. Requesters re-arbitrate after release.
- IDLE state:
  - write_en=0, ack=0.
  - If any req bit is set, pick the first set bit searching last+1, last+2, ... modulo NREQ.
  - Next edge: grant<=onehot(winner), owner<=winner, burst_cnt<=0, state BURST.
  - This costs a one-cycle arbitration bubble per grant.
  - If no req bit is set, stay in IDLE.
- BURST state:
  - accept = req[owner] & ~full.
  - write_en=accept; w_data=req_data[owner]; ack[owner]=accept; all other ack bits 0.
  - On accept: burst_cnt<=burst_cnt+1.
  - Burst ends (state IDLE, grant<=0, last<=owner, burst_cnt<=0) on either:
    - an accept with burst_cnt==MAX_BURST-1, or
    - req[owner]==0 sampled in BURST.
  - full=1 with req[owner]=1: stall. No write, no ack, counter holds, grant held indefinitely; other requesters wait.
  - Requests from non-owners are ignored until the next IDLE.
- Requester contract: hold req and req_data stable until ack. After ack, either present the next word or drop req in the following cycle.
- Simultaneous events:
  - Owner drops req in the same cycle full rises: the burst ends, no write.
  - The last allowed word is accepted while other requests are pending: arbitration in the next IDLE cycle starts from owner+1.
- Width rules:
  - burst_cnt never exceeds MAX_BURST-1 while visible in BURST.
  - Pointer increments modulo NREQ; wrap from NREQ-1 to 0.
- Throughput:
  - Maximum MAX_BURST words per MAX_BURST+1 cycles.
  - Single requester, continuous req: the pattern is MAX_BURST writes then one idle cycle, repeating.

Test Plan:
- Reset, then req=4'b0001 held, data 8'h00..8'h07 advanced on each ack, full=0 -> writes at cycles 2-5 (8'h00-8'h03), a bubble at cycle 6, then 8'h04-8'h07; grant=4'b0001 throughout each burst.
- req=4'b1111 all held, full=0 -> grant sequence 0001,0010,0100,1000,0001 with 4 writes each and burst_cnt 0..3; w_data matches the owner's data on each ack.
- Requester 2 granted, full forced high for 5 cycles after its second word -> write_en=0, ack=0, burst_cnt holds 2, grant stays 4'b0100; after full falls, 2 more words and then IDLE.
- Owner 1 drops req after 1 word while req0 and req3 are high -> burst ends with burst_cnt=1 written; next grant=4'b1000 (search from 2), then 4'b0001.
- clr_n pulsed low mid-burst (owner 3, burst_cnt=2) -> grant=0, busy=0, write_en=0 immediately; after release with req=4'b1001, the first grant is 4'b0001.
- Single word at MAX_BURST=1 with req=4'b0011 -> strictly alternating grants 0001/0010, each with one write followed by one bubble cycle.
